// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/crypto-wait/write-back; strobes decoded combinationally from state+op_q.
// Latency ALU 4, NOP/JMP/JZ 3, LOAD 5, STORE 4, ENC/DEC 4+crypto; stalls on mem_ready/crypto_done, halts on fault.
module cpu_ctrl_fsm #(
    parameter int OPCODE_W = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    input  logic                crypto_done,
    output logic                mem_re,
    output logic                mem_we,
    output logic                ir_load,
    output logic                pc_en,
    output logic                pc_load,
    output logic                reg_we,
    output logic [2:0]          alu_op,
    output logic                crypto_start,
    output logic                crypto_mode,
    output logic                halted,
    output logic                error,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ROL   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_ENC   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_DEC   = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(15);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_CWAIT  = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                halted_q, halted_d;
    logic                error_q, error_d;

    logic mem_re_c, mem_we_c, ir_load_c, pc_en_c, pc_load_c, reg_we_c, crypto_start_c;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        tmo_d          = tmo_q;
        halted_d       = halted_q;
        error_d        = error_q;
        mem_re_c       = 1'b0;
        mem_we_c       = 1'b0;
        ir_load_c      = 1'b0;
        pc_en_c        = 1'b0;
        pc_load_c      = 1'b0;
        reg_we_c       = 1'b0;
        crypto_start_c = 1'b0;
        alu_op         = 3'b000;
        crypto_mode    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re_c = 1'b1;
                if (mem_ready) begin
                    ir_load_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_XOR, OP_ROL: begin
                        alu_op  = op_q[2:0];
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_NOP: begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JZ: begin
                        pc_load_c = zero_flag;
                        pc_en_c   = ~zero_flag;
                        state_d   = S_FETCH;
                    end
                    OP_ENC, OP_DEC: begin
                        crypto_start_c = 1'b1;
                        crypto_mode    = op_q[1];
                        tmo_d          = '0;
                        state_d        = S_CWAIT;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        halted_d = 1'b1;
                        error_d  = 1'b1;
                        state_d  = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LOAD) begin
                    mem_re_c = 1'b1;
                end else begin
                    mem_we_c = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_CWAIT: begin
                crypto_mode = op_q[1];
                // done beats the timeout when both land in the same cycle
                if (crypto_done) begin
                    state_d = S_WB;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    halted_d = 1'b1;
                    error_d  = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_en_c  = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= '0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tmo_q    <= tmo_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            if (pc_en_c || pc_load_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Strobes are suppressed during the reset cycle so an abandoned instruction leaves no side effects.
    assign mem_re       = mem_re_c & ~reset;
    assign mem_we       = mem_we_c & ~reset;
    assign ir_load      = ir_load_c & ~reset;
    assign pc_en        = pc_en_c & ~reset;
    assign pc_load      = pc_load_c & ~reset;
    assign reg_we       = reg_we_c & ~reset;
    assign crypto_start = crypto_start_c & ~reset;

    assign halted      = halted_q;
    assign error       = error_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

    a_pc_excl: assert property (@(posedge clk) !(pc_en && pc_load));
    a_mem_excl: assert property (@(posedge clk) !(mem_re && mem_we));

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-instruction expected traces built from the opcode rules, checked every cycle.
module tb_cpu_ctrl_fsm;

    localparam int TIMEOUT = 64;

    // strobe vector order: {mem_re, mem_we, ir_load, pc_en, pc_load, reg_we}
    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] RE = 6'b100000;
    localparam logic [5:0] WE = 6'b010000;
    localparam logic [5:0] IR = 6'b001000;
    localparam logic [5:0] PE = 6'b000100;
    localparam logic [5:0] PL = 6'b000010;
    localparam logic [5:0] RW = 6'b000001;

    localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, CW = 3'd4, WB = 3'd5, HT = 3'd6;

    logic        clk = 1'b0;
    logic        reset, zero_flag, mem_ready, crypto_done;
    logic [3:0]  opcode;
    logic        mem_re, mem_we, ir_load, pc_en, pc_load, reg_we, crypto_start, crypto_mode, halted, error;
    logic [2:0]  alu_op, state;
    logic [15:0] instr_count;

    cpu_ctrl_fsm #(.OPCODE_W(4), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .crypto_done(crypto_done),
        .mem_re(mem_re), .mem_we(mem_we), .ir_load(ir_load), .pc_en(pc_en),
        .pc_load(pc_load), .reg_we(reg_we), .alu_op(alu_op), .crypto_start(crypto_start),
        .crypto_mode(crypto_mode), .halted(halted), .error(error), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int   m_count = 0;
    logic m_halted = 1'b0;
    logic m_error = 1'b0;
    logic bg_done = 1'b0;

    // expectations for the current cycle
    logic       e_vld = 1'b0;
    logic       e_chk_st;
    logic [2:0] e_st;
    logic [5:0] e_str;
    logic [2:0] e_alu;
    logic       e_cs;
    int         e_cm;
    int         e_cnt;
    logic       e_halt, e_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (e_vld) begin
            chk("strobes", {26'd0, mem_re, mem_we, ir_load, pc_en, pc_load, reg_we}, {26'd0, e_str});
            chk("alu_op", {29'd0, alu_op}, {29'd0, e_alu});
            chk("crypto_start", {31'd0, crypto_start}, {31'd0, e_cs});
            chk("inv_pc_excl", {31'd0, pc_en & pc_load}, 32'd0);
            chk("inv_mem_excl", {31'd0, mem_re & mem_we}, 32'd0);
            if (e_cm >= 0) chk("crypto_mode", {31'd0, crypto_mode}, e_cm[31:0]);
            if (e_chk_st) begin
                chk("state", {29'd0, state}, {29'd0, e_st});
                chk("instr_count", {16'd0, instr_count}, e_cnt[31:0] & 32'hFFFF);
                chk("halted", {31'd0, halted}, {31'd0, e_halt});
                chk("error", {31'd0, error}, {31'd0, e_err});
            end
        end
    end

    // One clock cycle: drive inputs, publish expectations, then advance the model's counters.
    task automatic cyc(input logic rst, input logic [3:0] opc, input logic zf, input logic mr,
                       input logic dn, input logic [2:0] st, input logic [5:0] strb,
                       input logic [2:0] alu, input logic cs, input int cm);
        reset = rst; opcode = opc; zero_flag = zf; mem_ready = mr; crypto_done = dn;
        e_chk_st = ~rst; e_st = st; e_str = rst ? NO : strb; e_alu = rst ? 3'd0 : alu;
        e_cs = rst ? 1'b0 : cs; e_cm = rst ? -1 : cm;
        e_cnt = m_count; e_halt = m_halted; e_err = m_error; e_vld = 1'b1;
        @(posedge clk); #1;
        if (rst) begin
            m_count = 0; m_halted = 1'b0; m_error = 1'b0;
        end else if (strb[2] || strb[1]) begin
            m_count = m_count + 1;
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, FE, NO, 3'd0, 1'b0, -1);
    endtask

    // fwait/mwait: ready-low cycles before the ready cycle; clat: CWAIT cycle carrying done (0 = never).
    task automatic instr(input logic [3:0] op, input logic zf, input int fwait, input int mwait, input int clat);
        logic [5:0] ms;
        for (int i = 0; i < fwait; i++) cyc(1'b0, op, zf, 1'b0, bg_done, FE, RE, 3'd0, 1'b0, -1);
        cyc(1'b0, op, zf, 1'b1, bg_done, FE, RE | IR, 3'd0, 1'b0, -1);
        cyc(1'b0, op, zf, 1'b1, bg_done, DE, NO, 3'd0, 1'b0, -1);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4: begin
                cyc(1'b0, op, zf, 1'b1, bg_done, EX, NO, op[2:0], 1'b0, -1);
                cyc(1'b0, op, zf, 1'b1, bg_done, WB, RW | PE, 3'd0, 1'b0, -1);
            end
            4'd5, 4'd6: begin
                ms = (op == 4'd5) ? RE : WE;
                cyc(1'b0, op, zf, 1'b1, bg_done, EX, NO, 3'd0, 1'b0, -1);
                for (int i = 0; i < mwait; i++) cyc(1'b0, op, zf, 1'b0, bg_done, ME, ms, 3'd0, 1'b0, -1);
                if (op == 4'd5) begin
                    cyc(1'b0, op, zf, 1'b1, bg_done, ME, ms, 3'd0, 1'b0, -1);
                    cyc(1'b0, op, zf, 1'b1, bg_done, WB, RW | PE, 3'd0, 1'b0, -1);
                end else begin
                    cyc(1'b0, op, zf, 1'b1, bg_done, ME, ms | PE, 3'd0, 1'b0, -1);
                end
            end
            4'd0: cyc(1'b0, op, zf, 1'b1, bg_done, EX, PE, 3'd0, 1'b0, -1);
            4'd7: cyc(1'b0, op, zf, 1'b1, bg_done, EX, PL, 3'd0, 1'b0, -1);
            4'd8: cyc(1'b0, op, zf, 1'b1, bg_done, EX, zf ? PL : PE, 3'd0, 1'b0, -1);
            4'd9, 4'd10: begin
                cyc(1'b0, op, zf, 1'b1, 1'b0, EX, NO, 3'd0, 1'b1, int'(op[1]));
                for (int k = 1; k <= TIMEOUT; k++) begin
                    if (clat == k) begin
                        cyc(1'b0, op, zf, 1'b1, 1'b1, CW, NO, 3'd0, 1'b0, int'(op[1]));
                        cyc(1'b0, op, zf, 1'b1, bg_done, WB, RW | PE, 3'd0, 1'b0, -1);
                        break;
                    end
                    cyc(1'b0, op, zf, 1'b1, 1'b0, CW, NO, 3'd0, 1'b0, int'(op[1]));
                    if (k == TIMEOUT) begin
                        m_halted = 1'b1; m_error = 1'b1;
                    end
                end
            end
            4'd15: begin
                cyc(1'b0, op, zf, 1'b1, bg_done, EX, NO, 3'd0, 1'b0, -1);
                m_halted = 1'b1;
            end
            default: begin
                cyc(1'b0, op, zf, 1'b1, bg_done, EX, NO, 3'd0, 1'b0, -1);
                m_halted = 1'b1; m_error = 1'b1;
            end
        endcase
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'b1, 1'($urandom), HT, NO, 3'd0, 1'b0, -1);
    endtask

    initial begin
        reset = 1'b1; opcode = 4'd0; zero_flag = 1'b0; mem_ready = 1'b0; crypto_done = 1'b0;
        @(posedge clk); #1;
        do_reset();
        do_reset();

        instr(4'd1, 1'b0, 0, 0, 0);
        chk("lit_add_count", {16'd0, instr_count}, 32'd1);
        chk("lit_add_state", {29'd0, state}, 32'd0);

        do_reset();
        instr(4'd8, 1'b1, 0, 0, 0);
        instr(4'd8, 1'b0, 0, 0, 0);
        chk("lit_jz_count", {16'd0, instr_count}, 32'd2);

        bg_done = 1'b1;
        instr(4'd2, 1'b0, 2, 0, 0);
        instr(4'd3, 1'b1, 1, 0, 0);
        instr(4'd4, 1'b0, 0, 0, 0);
        instr(4'd5, 1'b0, 0, 3, 0);
        instr(4'd6, 1'b0, 1, 2, 0);
        instr(4'd0, 1'b0, 0, 0, 0);
        instr(4'd7, 1'b1, 0, 0, 0);
        bg_done = 1'b0;
        chk("lit_mix_count", {16'd0, instr_count}, 32'd9);

        instr(4'd9, 1'b0, 0, 0, 10);
        instr(4'd10, 1'b0, 0, 0, 3);
        instr(4'd10, 1'b0, 0, 0, TIMEOUT);
        chk("lit_done_wins_halted", {31'd0, halted}, 32'd0);
        chk("lit_crypto_count", {16'd0, instr_count}, 32'd12);

        do_reset();
        instr(4'd9, 1'b0, 0, 0, 0);
        hold_halt(5);
        chk("lit_timeout_halted", {31'd0, halted}, 32'd1);
        chk("lit_timeout_error", {31'd0, error}, 32'd1);
        chk("lit_timeout_state", {29'd0, state}, 32'd6);

        do_reset();
        instr(4'd11, 1'b0, 0, 0, 0);
        hold_halt(20);
        chk("lit_illegal_error", {31'd0, error}, 32'd1);

        do_reset();
        instr(4'd15, 1'b0, 0, 0, 0);
        hold_halt(3);
        chk("lit_halt_halted", {31'd0, halted}, 32'd1);
        chk("lit_halt_error", {31'd0, error}, 32'd0);

        // reset while a STORE is waiting in MEM, with ready arriving on the reset cycle
        do_reset();
        instr(4'd1, 1'b0, 0, 0, 0);
        cyc(1'b0, 4'd6, 1'b0, 1'b1, 1'b0, FE, RE | IR, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd6, 1'b0, 1'b1, 1'b0, DE, NO, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd6, 1'b0, 1'b1, 1'b0, EX, NO, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd6, 1'b0, 1'b0, 1'b0, ME, WE, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd6, 1'b0, 1'b0, 1'b0, ME, WE, 3'd0, 1'b0, -1);
        do_reset();
        chk("lit_rst_mem_count", {16'd0, instr_count}, 32'd0);
        instr(4'd0, 1'b0, 0, 0, 0);

        // reset while waiting on the crypto engine, with done arriving on the reset cycle
        cyc(1'b0, 4'd9, 1'b0, 1'b1, 1'b0, FE, RE | IR, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd9, 1'b0, 1'b1, 1'b0, DE, NO, 3'd0, 1'b0, -1);
        cyc(1'b0, 4'd9, 1'b0, 1'b1, 1'b0, EX, NO, 3'd0, 1'b1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd9, 1'b0, 1'b1, 1'b0, CW, NO, 3'd0, 1'b0, 0);
        do_reset();
        chk("lit_rst_cw_state", {29'd0, state}, 32'd0);
        instr(4'd1, 1'b0, 0, 0, 0);
        chk("lit_final_count", {16'd0, instr_count}, 32'd1);

        e_vld = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
